// File: rtl/l2_ram_multi_bank_init_if.sv
// Multi-bank L2 RAM access bus.
// Per-bank request, byte-enable, address, data and response lanes.
interface l2_ram_multi_bank_init_if #(
  parameter int NB_BANKS   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_BANKS-1:0]            req_i;
  logic [NB_BANKS-1:0]            we_i;
  logic [NB_BANKS*BE_WIDTH-1:0]   be_i;
  logic [NB_BANKS*ADDR_WIDTH-1:0] addr_i;
  logic [NB_BANKS*DATA_WIDTH-1:0] wdata_i;
  logic [NB_BANKS-1:0]            gnt_o;
  logic [NB_BANKS-1:0]            rvalid_o;
  logic [NB_BANKS*DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/l2_ram_multi_bank_init.sv
// Interleaved single-port L2 RAM banks with a shared
// zero-initialisation sequencer triggered by init_ni edges.
module l2_ram_multi_bank_init #(
  parameter int NB_BANKS   = 4,
  parameter int BANK_SIZE  = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_ni,
  input  logic test_mode_i,
  output logic init_busy_o,
  output logic init_done_o,
  l2_ram_multi_bank_init_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(BANK_SIZE);
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH:0] LIMIT =
    BANK_SIZE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(BANK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  init_q;
  logic                  start;

  assign start = init_q & ~init_ni & ~test_mode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      init_q  <= init_ni;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      INIT: begin
        // start events and test_mode are ignored here
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign init_busy_o = (state_q == INIT);
  assign init_done_o = done_q;
  assign bus.gnt_o   = bus.req_i
                     & {NB_BANKS{~init_busy_o}};

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  hit;
    logic                  gnt;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign addr  = bus.addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign be    = bus.be_i[b*BE_WIDTH +: BE_WIDTH];
    assign wdata = bus.wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign gnt   = bus.gnt_o[b];
    assign hit   = {1'b0, addr} < LIMIT;

    always_ff @(posedge clk_i) begin
      if (init_busy_o) begin
        mem[cnt_q] <= '0;
      end else if (gnt && bus.we_i[b] && hit) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end

    // writes and out-of-range reads answer with zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt;
        if (gnt) begin
          rdata_q <= (!bus.we_i[b] && hit) ? mem[addr] : '0;
        end
      end
    end

    assign bus.rvalid_o[b] = rvalid_q;
    assign bus.rdata_o[b*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
  end
endmodule

// File: tb/tb_l2_ram_multi_bank_init.sv
// Directed bench for l2_ram_multi_bank_init:
// init sequence, byte writes, range handling, reset.
module tb_l2_ram_multi_bank_init;
  localparam int NB = 4;
  localparam int BS = 1000;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic init_ni;
  logic test_mode;
  logic busy;
  logic done;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  l2_ram_multi_bank_init_if #(
    .NB_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  l2_ram_multi_bank_init #(
    .NB_BANKS(NB), .BANK_SIZE(BS), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .init_ni(init_ni),
    .test_mode_i(test_mode),
    .init_busy_o(busy),
    .init_done_o(done),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
  endtask

  task automatic access(input int b, input logic we,
                        input logic [BW-1:0] be,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    idle_bus();
    bus.req_i[b]            = 1'b1;
    bus.we_i[b]             = we;
    bus.be_i[b*BW +: BW]    = be;
    bus.addr_i[b*AW +: AW]  = a;
    bus.wdata_i[b*DW +: DW] = wd;
  endtask

  function automatic logic [DW-1:0] rd(input int b);
    return bus.rdata_o[b*DW +: DW];
  endfunction

  int busy_cnt;
  int bad;

  initial begin
    rst_ni    = 1'b0;
    init_ni   = 1'b1;
    test_mode = 1'b0;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // start blocked by test mode
    test_mode = 1'b1;
    init_ni   = 1'b0;
    repeat (4) @(negedge clk);
    chk("tm_busy", busy, 0);
    chk("tm_done", done, 0);
    init_ni = 1'b1;
    @(negedge clk);
    test_mode = 1'b0;
    @(negedge clk);

    // full init pulse with access attempts during INIT
    init_ni  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k == 0) init_ni = 1'b1;
      if (k == 3) begin
        bus.req_i   = 4'b1111;
        bus.we_i    = 4'b1111;
        bus.be_i    = '1;
        bus.wdata_i = '1;
        #1 chk("init_gnt", bus.gnt_o, 0);
      end
      if (k == 5) begin
        chk("init_rvalid", bus.rvalid_o, 0);
        idle_bus();
      end
      if (k == 4) test_mode = 1'b1;
      if (k == 8) test_mode = 1'b0;
    end
    chk("init_len", busy_cnt, BS);
    chk("init_done", done, 1);

    // every word of every bank reads zero
    bad = 0;
    bus.req_i = 4'b1111;
    for (int a = 0; a < BS; a++) begin
      for (int b = 0; b < NB; b++) bus.addr_i[b*AW +: AW] = AW'(a);
      @(negedge clk);
      if (bus.rvalid_o !== 4'b1111 || bus.rdata_o !== '0) bad++;
    end
    idle_bus();
    chk("zero_scan", bad, 0);

    // byte-masked write then read back
    access(2, 1'b1, 4'b0101, 10'd5, 32'hDEADBEEF);
    #1 chk("wr_gnt", bus.gnt_o, 4'b0100);
    @(negedge clk);
    chk("wr_rvalid", bus.rvalid_o, 4'b0100);
    chk("wr_rdata", rd(2), 0);
    access(2, 1'b0, 4'b0000, 10'd5, 32'h0);
    @(negedge clk);
    chk("be_rvalid", bus.rvalid_o, 4'b0100);
    chk("be_rdata", rd(2), 32'h00AD00EF);
    idle_bus();
    @(negedge clk);
    chk("hold_rvalid", bus.rvalid_o, 0);
    chk("hold_rdata", rd(2), 32'h00AD00EF);

    // out-of-range address
    access(1, 1'b0, 4'b0000, 10'd1010, 32'h0);
    #1 chk("oor_gnt", bus.gnt_o, 4'b0010);
    @(negedge clk);
    chk("oor_rvalid", bus.rvalid_o, 4'b0010);
    chk("oor_rdata", rd(1), 0);
    access(1, 1'b1, 4'b1111, 10'd1010, 32'hCAFEF00D);
    @(negedge clk);
    chk("oor_wr_rvalid", bus.rvalid_o, 4'b0010);
    access(1, 1'b0, 4'b0000, 10'd1010, 32'h0);
    @(negedge clk);
    chk("oor_rd_after_wr", rd(1), 0);
    access(1, 1'b0, 4'b0000, 10'd999, 32'h0);
    @(negedge clk);
    chk("last_addr_zero", rd(1), 0);

    // write followed by read next cycle
    access(0, 1'b1, 4'b1111, 10'd7, 32'h12345678);
    @(negedge clk);
    access(0, 1'b0, 4'b0000, 10'd7, 32'h0);
    @(negedge clk);
    chk("wr_rd_rdata", rd(0), 32'h12345678);
    idle_bus();
    @(negedge clk);

    // reset in the middle of INIT
    init_ni = 1'b0;
    @(negedge clk);
    init_ni = 1'b1;
    repeat (499) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_ni = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rvalid", bus.rvalid_o, 0);
    chk("mr_rdata", bus.rdata_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // restart with init_ni held low throughout and after DONE
    init_ni  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("re_len", busy_cnt, BS);
    chk("re_done", done, 1);
    busy_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("held_no_retrig", busy_cnt, 0);
    init_ni = 1'b1;
    @(negedge clk);
    chk("rise_no_start", busy, 0);

    access(2, 1'b0, 4'b0000, 10'd5, 32'h0);
    @(negedge clk);
    chk("re_zero_b2", rd(2), 0);
    access(0, 1'b0, 4'b0000, 10'd7, 32'h0);
    @(negedge clk);
    chk("re_zero_b0", rd(0), 0);
    idle_bus();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/l2_ram_multi_bank_init.md
L2_RAM_MULTI_BANK_INIT -- requirements
Module: l2_ram_multi_bank_init

Interface
REQ-001 SHALL have parameter NB_BANKS, default 4, number of interleaved banks (1..16).
REQ-002 SHALL have parameter BANK_SIZE, default 1024, words per bank; need not be a power of two.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width, a multiple of 8.
REQ-004 SHALL derive localparam ADDR_WIDTH = $clog2(BANK_SIZE) and BE_WIDTH = DATA_WIDTH/8.
REQ-005 SHALL have clk_i  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have init_ni  input  1  active-low zero-initialisation request, edge-qualified.
REQ-008 SHALL have test_mode_i  input  1  when 1, blocks the start of initialisation.
REQ-009 SHALL have req_i  input  NB_BANKS  per-bank access request.
REQ-010 SHALL have we_i  input  NB_BANKS  per-bank write enable (1 = write).
REQ-011 SHALL have be_i  input  NB_BANKS*BE_WIDTH  per-bank byte enables, bank b at slice b.
REQ-012 SHALL have addr_i  input  NB_BANKS*ADDR_WIDTH  per-bank word address.
REQ-013 SHALL have wdata_i  input  NB_BANKS*DATA_WIDTH  per-bank write data.
REQ-014 SHALL have gnt_o  output  NB_BANKS  per-bank grant, combinational.
REQ-015 SHALL have rvalid_o  output  NB_BANKS  per-bank response valid, registered.
REQ-016 SHALL have rdata_o  output  NB_BANKS*DATA_WIDTH  per-bank read data, registered.
REQ-017 SHALL have init_busy_o  output  1  high while zero-initialisation runs.
REQ-018 SHALL have init_done_o  output  1  sticky, high once initialisation completes.

Function
REQ-019 SHALL contain NB_BANKS independent single-port BANK_SIZE x DATA_WIDTH arrays.
REQ-020 SHALL implement FSM IDLE, INIT, DONE, controlling all banks together.
REQ-021 SHALL register init_ni and treat a 1->0 transition with test_mode_i=0 as the start event; a level held low SHALL NOT retrigger.
REQ-022 IDLE or DONE + start event -> INIT; counter cleared to 0; init_done_o cleared.
REQ-023 In INIT, each cycle SHALL write all-zero to address counter in every bank, then increment.
REQ-024 INIT SHALL last exactly BANK_SIZE cycles; on counter = BANK_SIZE-1 -> DONE, init_busy_o falls and init_done_o rises the next cycle.
REQ-025 init_busy_o SHALL equal (state == INIT).
REQ-026 gnt_o[b] SHALL equal req_i[b] & ~init_busy_o; accesses are ignored during INIT.
REQ-027 A granted write SHALL update only bytes with be_i set, same cycle.
REQ-028 A granted access (read or write) SHALL assert rvalid_o[b] exactly one cycle later; rdata_o[b] SHALL hold read data for reads and 0 for writes.
REQ-029 rdata_o[b] SHALL hold its value when rvalid_o[b] is low.
REQ-030 addr_i >= BANK_SIZE SHALL be granted; write discarded, read returns 0 with rvalid.
REQ-031 Read of an address written in the previous cycle SHALL return the new data (no bypass needed; array order).
REQ-032 A start event during INIT SHALL be ignored; the sequence is not restarted.
REQ-033 test_mode_i rising during INIT SHALL NOT abort the sequence.

Reset
REQ-034 While rst_ni=0: state IDLE, counter 0, gnt-related registers 0, rvalid_o 0, rdata_o 0, init_busy_o 0, init_done_o 0, init_ni sample register 1.
REQ-035 Reset during INIT SHALL return to IDLE with init_done_o 0; array contents then unspecified.
REQ-036 Array contents SHALL NOT be reset.

Verification
REQ-037 NB_BANKS=4, BANK_SIZE=1000: pulse init_ni low -> init_busy_o high for exactly 1000 cycles, init_done_o=1 after; read every address of all banks -> 0.
REQ-038 Write 0xDEADBEEF be=4'b0101 to bank 2 addr 5 over a word of 0 -> read returns 0x00AD00EF, rvalid one cycle after gnt.
REQ-039 req_i=4'b1111 during INIT -> gnt_o=0, no rvalid, memory unchanged except zeros.
REQ-040 Read addr 1010 (BANK_SIZE=1000) -> gnt=1, rvalid next cycle, rdata=0; write there -> no array change.
REQ-041 Assert rst_ni low at init cycle 500 -> all outputs 0; new init_ni edge -> full 1000-cycle sequence.
REQ-042 init_ni falling with test_mode_i=1 -> stays IDLE; init_ni held low 50 cycles after DONE -> no second INIT.
